// File: rtl/hack_pkg.sv
// Shared widths, types and FSM encoding for the Hack register-bank blocks.
package hack_pkg;
   localparam int WORD_W   = 16;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 8;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic {IDLE, CLEAR} ram8_state_e;
endpackage

// File: rtl/mux8way16.sv
// 8-way 16-bit selector: a..z picked by s (a for 0, z for 7).
module mux8way16
   import hack_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic [WORD_W-1:0] c,
   input  logic [WORD_W-1:0] d,
   input  logic [WORD_W-1:0] w,
   input  logic [WORD_W-1:0] x,
   input  logic [WORD_W-1:0] y,
   input  logic [WORD_W-1:0] z,
   input  logic [ADDR_W-1:0] s,
   output logic [WORD_W-1:0] out
);
   always_comb begin
      out = a;
      case (s)
         3'd0: out = a;
         3'd1: out = b;
         3'd2: out = c;
         3'd3: out = d;
         3'd4: out = w;
         3'd5: out = x;
         3'd6: out = y;
         3'd7: out = z;
         default: out = a;
      endcase
   end
endmodule

// File: rtl/ram8_bank16.sv
// Eight 16-bit registers with a sync write port, 1-cycle registered read port
// (write-first bypass) and a sequential clear sweep that blocks access while busy.
module ram8_bank16
   import hack_pkg::*;
#(
   parameter logic [WORD_W-1:0] CLR_VAL = 16'h0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] in_data,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_req,
   input  logic              clr_req,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy
);
   ram8_state_e state, state_nxt;
   addr_t       cnt;
   logic [NUM_REGS-1:0][WORD_W-1:0] regs;
   logic [NUM_REGS-1:0]             we;
   word_t       wdata;
   word_t       mux_out;
   logic        idle_acc;
   logic        wr_acc;
   logic        rd_acc;

   // A clear request wins its own cycle: same-edge write/read are dropped.
   assign idle_acc = (state == IDLE) && !clr_req;
   assign wr_acc   = idle_acc && wr_en;
   assign rd_acc   = idle_acc && rd_req;
   assign busy     = (state == CLEAR);
   assign wdata    = busy ? CLR_VAL : in_data;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (clr_req) state_nxt = CLEAR;
         CLEAR:   if (cnt == addr_t'(NUM_REGS-1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      we = '0;
      if (busy)        we[cnt]     = 1'b1;
      else if (wr_acc) we[wr_addr] = 1'b1;
   end

   mux8way16 u_mux (
      .a(regs[0]), .b(regs[1]), .c(regs[2]), .d(regs[3]),
      .w(regs[4]), .x(regs[5]), .y(regs[6]), .z(regs[7]),
      .s(rd_addr), .out(mux_out)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         regs     <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         state    <= state_nxt;
         if (busy) cnt <= cnt + addr_t'(1);
         for (int i = 0; i < NUM_REGS; i++)
            if (we[i]) regs[i] <= wdata;
         rd_valid <= rd_acc;
         if (rd_acc)
            rd_data <= (wr_acc && (wr_addr == rd_addr)) ? in_data : mux_out;
      end
   end
endmodule

// File: tb/tb_ram8_bank16.sv
// Directed bench for ram8_bank16: reset, read/write, bypass, clear sweep, reset abort.
module tb_ram8_bank16;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] in_data;
   logic [2:0]  wr_addr;
   logic        wr_en;
   logic [2:0]  rd_addr;
   logic        rd_req;
   logic        clr_req;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        busy;

   int errors = 0;
   int checks = 0;

   ram8_bank16 #(.CLR_VAL(16'hA5A5)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .wr_addr(wr_addr),
      .wr_en(wr_en), .rd_addr(rd_addr), .rd_req(rd_req), .clr_req(clr_req),
      .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0; rd_req = 1'b0; clr_req = 1'b0;
      in_data = '0; wr_addr = '0; rd_addr = '0;
   endtask

   task automatic write_word(input logic [2:0] a, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; in_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   // Reads each address back-to-back and compares against exp[].
   task automatic read_all(input string tag, input logic [15:0] exp [8]);
      for (int a = 0; a < 8; a++) begin
         rd_req = 1'b1; rd_addr = 3'(a);
         tick();
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== exp[a]) begin
            errors++;
            $display("FAIL %s addr%0d: got valid=%b data=%h, want valid=1 data=%h",
                     tag, a, rd_valid, rd_data, exp[a]);
         end
      end
      rd_req = 1'b0;
   endtask

   // Counts busy cycles after the clr_req edge; rd_valid must stay low throughout.
   task automatic run_clear(input string tag, input logic [15:0] frozen, input bit chk_frozen,
                            output int n);
      n = 0;
      while (busy === 1'b1 && n < 20) begin
         checks++;
         if (rd_valid !== 1'b0 || (chk_frozen && rd_data !== frozen)) begin
            errors++;
            $display("FAIL %s during busy: got valid=%b data=%h, want valid=0 data=%h",
                     tag, rd_valid, rd_data, frozen);
         end
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      logic [15:0] zeros [8];
      idle_inputs();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      checks++;
      if (rd_data !== 16'h0 || rd_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got data=%h valid=%b busy=%b, want 0000 0 0",
                  rd_data, rd_valid, busy);
      end
      for (int i = 0; i < 8; i++) zeros[i] = 16'h0;
      read_all("reset_read", zeros);
      tick();
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL valid_pulse: got valid=%b, want 0", rd_valid);
      end
   endtask

   task automatic test_write_read();
      logic [15:0] exp [8];
      exp[0] = 16'h0;
      for (int k = 1; k < 8; k++) begin
         exp[k] = 16'h1111 * 16'(k);
         write_word(3'(k), exp[k]);
      end
      read_all("b2b_read", exp);
      tick();
   endtask

   task automatic test_bypass();
      wr_en = 1'b1; wr_addr = 3'd3; in_data = 16'hBEEF;
      rd_req = 1'b1; rd_addr = 3'd3;
      tick();
      idle_inputs();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF) begin
         errors++;
         $display("FAIL bypass: got valid=%b data=%h, want 1 beef", rd_valid, rd_data);
      end
      // Different-address collision is independent: reads the old word.
      wr_en = 1'b1; wr_addr = 3'd4; in_data = 16'hCAFE;
      rd_req = 1'b1; rd_addr = 3'd5;
      tick();
      idle_inputs();
      checks++;
      if (rd_data !== 16'h5555) begin
         errors++;
         $display("FAIL diff_addr: got %h, want 5555", rd_data);
      end
      rd_req = 1'b1; rd_addr = 3'd3;
      tick();
      rd_addr = 3'd4;
      checks++;
      if (rd_data !== 16'hBEEF) begin
         errors++;
         $display("FAIL reread3: got %h, want beef", rd_data);
      end
      tick();
      rd_req = 1'b0;
      checks++;
      if (rd_data !== 16'hCAFE) begin
         errors++;
         $display("FAIL reread4: got %h, want cafe", rd_data);
      end
      tick();
   endtask

   task automatic test_clear();
      logic [15:0] exp [8];
      int n;
      for (int k = 0; k < 8; k++) write_word(3'(k), 16'hF000 | 16'(k + 1));
      clr_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; in_data = 16'h1234;
      rd_req = 1'b1; rd_addr = 3'd6;
      tick();
      idle_inputs();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL clear_start: got busy=%b, want 1", busy);
      end
      run_clear("clear", 16'h0, 1'b0, n);
      checks++;
      if (n != 8) begin
         errors++;
         $display("FAIL busy_len: got %0d cycles, want 8", n);
      end
      for (int i = 0; i < 8; i++) exp[i] = 16'hA5A5;
      read_all("after_clear", exp);
      tick();
   endtask

   task automatic test_reset_abort();
      logic [15:0] exp [8];
      int n;
      for (int k = 0; k < 8; k++) write_word(3'(k), 16'h0F00 | 16'(k + 1));
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      tick(); tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (busy !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 16'h0) begin
         errors++;
         $display("FAIL abort_state: got busy=%b valid=%b data=%h, want 0 0 0000",
                  busy, rd_valid, rd_data);
      end
      for (int i = 0; i < 8; i++) exp[i] = 16'h0;
      read_all("after_abort", exp);
      tick();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      run_clear("reclear", 16'h0, 1'b0, n);
      checks++;
      if (n != 8) begin
         errors++;
         $display("FAIL reclear_len: got %0d cycles, want 8", n);
      end
      for (int i = 0; i < 8; i++) exp[i] = 16'hA5A5;
      read_all("after_reclear", exp);
      tick();
   endtask

   task automatic test_read_across_clear();
      int n;
      write_word(3'd1, 16'h1234);
      rd_req = 1'b1; rd_addr = 3'd1;
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 16'h1234) begin
         errors++;
         $display("FAIL pre_clear_read: got valid=%b data=%h, want 1 1234", rd_valid, rd_data);
      end
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      run_clear("held_read", 16'h1234, 1'b1, n);
      checks++;
      if (n != 8 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL busy_fall: got %0d cycles valid=%b, want 8 0", n, rd_valid);
      end
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 16'hA5A5) begin
         errors++;
         $display("FAIL resume: got valid=%b data=%h, want 1 a5a5", rd_valid, rd_data);
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_clear();
      test_reset_abort();
      test_read_across_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
